// File: rtl/calc_result_accum.sv
// Frame reducer for the calculate-stage result stream: sums, counts threshold hits
// and tracks the signed maximum over FRAME_LEN beats, then holds a summary for the consumer.
module calc_result_accum #(
    parameter int                        DATA_W    = 32,
    parameter int                        ACC_W     = 40,
    parameter int                        FRAME_LEN = 8,
    parameter logic signed [DATA_W-1:0]  THRESH    = 1000,
    localparam int                       CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     flush,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic signed [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]         out_hits,
    output logic signed [DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]         out_cnt,
    output logic                     busy,
    output logic                     dbg_state
);
    // Handshake: a beat transfers on any edge where vld && rdy. in_rdy depends only on
    // the state register; out_vld and out_* stay constant from assertion until out_rdy.
    typedef enum logic {ST_ACCUM = 1'b0, ST_EMIT = 1'b1} state_t;

    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t                     r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic signed [ACC_W-1:0]    r_sum;
    logic [CNT_W-1:0]           r_hits;
    logic signed [DATA_W-1:0]   r_max;
    logic                       r_out_vld;
    logic signed [ACC_W-1:0]    r_out_sum;
    logic [CNT_W-1:0]           r_out_hits;
    logic signed [DATA_W-1:0]   r_out_max;
    logic [CNT_W-1:0]           r_out_cnt;

    logic                       w_accept;
    logic                       w_hit;
    logic signed [ACC_W-1:0]    w_data_ext;
    logic signed [ACC_W-1:0]    w_sum_nxt;
    logic [CNT_W-1:0]           w_hits_nxt;
    logic signed [DATA_W-1:0]   w_max_nxt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic                       w_close;

    assign w_accept   = in_vld && (r_state == ST_ACCUM);
    assign w_hit      = w_accept && (in_data > THRESH);
    assign w_data_ext = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
    assign w_sum_nxt  = w_accept ? (r_sum + w_data_ext) : r_sum;
    assign w_hits_nxt = r_hits + CNT_W'(w_hit);
    // Strict greater-than so a tie keeps the value already held.
    assign w_max_nxt  = (w_accept && (in_data > r_max)) ? in_data : r_max;
    assign w_cnt_nxt  = r_cnt + CNT_W'(w_accept);
    assign w_close    = (r_state == ST_ACCUM) &&
                        ((w_accept && (w_cnt_nxt == CNT_W'(FRAME_LEN))) ||
                         (flush && ((r_cnt != '0) || w_accept)));

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state    <= ST_ACCUM;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_hits     <= '0;
            r_max      <= MOST_NEG;
            r_out_vld  <= 1'b0;
            r_out_sum  <= '0;
            r_out_hits <= '0;
            r_out_max  <= '0;
            r_out_cnt  <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_close) begin
                        r_out_sum  <= w_sum_nxt;
                        r_out_hits <= w_hits_nxt;
                        r_out_max  <= w_max_nxt;
                        r_out_cnt  <= w_cnt_nxt;
                        r_out_vld  <= 1'b1;
                        r_cnt      <= '0;
                        r_sum      <= '0;
                        r_hits     <= '0;
                        r_max      <= MOST_NEG;
                        r_state    <= ST_EMIT;
                    end else begin
                        r_cnt  <= w_cnt_nxt;
                        r_sum  <= w_sum_nxt;
                        r_hits <= w_hits_nxt;
                        r_max  <= w_max_nxt;
                    end
                end
                ST_EMIT: begin
                    if (out_rdy) begin
                        r_out_vld <= 1'b0;
                        r_state   <= ST_ACCUM;
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

    assign in_rdy    = (r_state == ST_ACCUM);
    assign out_vld   = r_out_vld;
    assign out_sum   = r_out_sum;
    assign out_hits  = r_out_hits;
    assign out_max   = r_out_max;
    assign out_cnt   = r_out_cnt;
    assign busy      = (r_cnt != '0) || r_out_vld;
    assign dbg_state = (r_state == ST_EMIT);
endmodule

// File: tb/tb_calc_result_accum.sv
// Directed bench for calc_result_accum: table of whole frames plus hand-written
// sequences for backpressure, flush and reset corner cases.
module tb_calc_result_accum;
    logic        ap_clk;
    logic        ap_rst;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_data;
    logic        flush;
    logic        out_vld;
    logic        out_rdy;
    logic [39:0] out_sum;
    logic [3:0]  out_hits;
    logic [31:0] out_max;
    logic [3:0]  out_cnt;
    logic        busy;
    logic        dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    calc_result_accum dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .flush     (flush),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_sum   (out_sum),
        .out_hits  (out_hits),
        .out_max   (out_max),
        .out_cnt   (out_cnt),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    typedef struct {
        string       name;
        logic [31:0] d[8];
        int          n;
        bit          fl;
        logic [39:0] sum;
        logic [3:0]  hits;
        logic [31:0] mx;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input bit fl);
        in_vld  = 1'b1;
        in_data = d;
        flush   = fl;
        tick();
        in_vld  = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic chk_summary(input string name, input logic [39:0] sum, input logic [3:0] hits,
                               input logic [31:0] mx, input logic [3:0] cnt);
        chk({name, ".out_vld"}, 64'(out_vld), 64'd1);
        chk({name, ".sum"},     64'(out_sum), 64'(sum));
        chk({name, ".hits"},    64'(out_hits), 64'(hits));
        chk({name, ".max"},     64'(out_max), 64'(mx));
        chk({name, ".cnt"},     64'(out_cnt), 64'(cnt));
    endtask

    initial begin
        vecs[0] = '{name: "count_up", d: '{1, 2, 3, 4, 5, 6, 7, 8}, n: 8, fl: 1'b0,
                    sum: 40'd36, hits: 4'd0, mx: 32'd8, cnt: 4'd8};
        vecs[1] = '{name: "thresh", d: '{1001, 1000, -5, 2000, 0, 1001, -1, 7}, n: 8, fl: 1'b0,
                    sum: 40'd5003, hits: 4'd3, mx: 32'd2000, cnt: 4'd8};
        vecs[2] = '{name: "most_neg", d: '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                                        32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000},
                    n: 8, fl: 1'b0, sum: 40'hFC00000000, hits: 4'd0, mx: 32'h80000000, cnt: 4'd8};
        vecs[3] = '{name: "all_neg", d: '{-1, -2, -3, -4, -5, -6, -7, -8}, n: 8, fl: 1'b0,
                    sum: 40'hFFFFFFFFDC, hits: 4'd0, mx: 32'hFFFFFFFF, cnt: 4'd8};
        vecs[4] = '{name: "mixed", d: '{-100, 5000, 3, 1001, 32'h80000000, 32'h7FFFFFFF, 0, 999},
                    n: 8, fl: 1'b0, sum: 40'd6902, hits: 4'd3, mx: 32'h7FFFFFFF, cnt: 4'd8};
        vecs[5] = '{name: "flush_beat", d: '{10, 20, 30, 40, 0, 0, 0, 0}, n: 4, fl: 1'b1,
                    sum: 40'd100, hits: 4'd0, mx: 32'd40, cnt: 4'd4};

        ap_rst  = 1'b1;
        in_vld  = 1'b0;
        in_data = '0;
        flush   = 1'b0;
        out_rdy = 1'b1;
        repeat (3) tick();
        chk("rst.out_vld", 64'(out_vld), 64'd0);
        chk("rst.in_rdy",  64'(in_rdy), 64'd1);
        chk("rst.busy",    64'(busy), 64'd0);
        chk("rst.sum",     64'(out_sum), 64'd0);
        chk("rst.max",     64'(out_max), 64'd0);
        chk("rst.cnt",     64'(out_cnt), 64'd0);
        chk("rst.state",   64'(dbg_state), 64'd0);
        ap_rst = 1'b0;
        tick();

        // Table-driven frames, out_rdy held high.
        foreach (vecs[v]) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                if (i == 0) chk({vecs[v].name, ".in_rdy_open"}, 64'(in_rdy), 64'd1);
                beat(vecs[v].d[i], vecs[v].fl && (i == vecs[v].n - 1));
            end
            chk_summary(vecs[v].name, vecs[v].sum, vecs[v].hits, vecs[v].mx, vecs[v].cnt);
            chk({vecs[v].name, ".in_rdy_emit"}, 64'(in_rdy), 64'd0);
            chk({vecs[v].name, ".busy_emit"},   64'(busy), 64'd1);
            tick();
            chk({vecs[v].name, ".out_vld_drop"}, 64'(out_vld), 64'd0);
            chk({vecs[v].name, ".in_rdy_back"},  64'(in_rdy), 64'd1);
        end

        // flush with nothing open is ignored.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle.out_vld", 64'(out_vld), 64'd0);
        chk("flush_idle.busy",    64'(busy), 64'd0);
        tick();
        chk("flush_idle.out_vld2", 64'(out_vld), 64'd0);

        // flush on a cycle with no beat closes an open partial frame.
        beat(32'd7, 1'b0);
        beat(-32'sd3, 1'b0);
        chk("flush_part.busy", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_summary("flush_part", 40'd4, 4'd0, 32'd7, 4'd2);
        tick();

        // Backpressure: summary must hold while downstream stalls, and no beats accepted.
        out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) beat(32'd3, 1'b0);
        in_vld  = 1'b1;
        in_data = 32'd100;
        for (int k = 0; k < 5; k++) begin
            chk_summary("bp_hold", 40'd24, 4'd0, 32'd3, 4'd8);
            chk("bp_hold.in_rdy", 64'(in_rdy), 64'd0);
            tick();
        end
        out_rdy = 1'b1;
        tick();
        chk("bp_rel.out_vld", 64'(out_vld), 64'd0);
        chk("bp_rel.in_rdy",  64'(in_rdy), 64'd1);
        chk("bp_rel.busy",    64'(busy), 64'd0);
        for (int i = 0; i < 8; i++) beat(-32'sd5, 1'b0);
        chk_summary("bp_next", 40'hFFFFFFFFD8, 4'd0, 32'hFFFFFFFB, 4'd8);
        tick();

        // Reset mid-frame discards partial totals.
        for (int i = 0; i < 5; i++) beat(32'd9, 1'b0);
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        chk("rst_mid.busy",    64'(busy), 64'd0);
        chk("rst_mid.out_vld", 64'(out_vld), 64'd0);
        for (int i = 0; i < 7; i++) begin
            beat(32'd2, 1'b0);
            chk("rst_mid.no_early_vld", 64'(out_vld), 64'd0);
        end
        beat(32'd2, 1'b0);
        chk_summary("rst_mid", 40'd16, 4'd0, 32'd2, 4'd8);
        tick();

        // Reset while a summary is pending drops it.
        out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) beat(32'd1500, 1'b0);
        chk_summary("rst_emit_pre", 40'd12000, 4'd8, 32'd1500, 4'd8);
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        out_rdy = 1'b1;
        chk("rst_emit.out_vld", 64'(out_vld), 64'd0);
        chk("rst_emit.sum",     64'(out_sum), 64'd0);
        chk("rst_emit.in_rdy",  64'(in_rdy), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
